// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: default widths, opcodes and fetch FSM state type.
package mips_pkg;

    localparam int PC_W   = 5;
    localparam int INST_W = 32;

    localparam logic [5:0] OP_J = 6'b000010;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// IF/ID handshake between the fetch stage (master) and decode (slave).
interface inst_fetch_if #(
    parameter int PC_W   = 5,
    parameter int INST_W = 32
);
    logic              id_valid_o;
    logic              id_ready_i;
    logic [INST_W-1:0] id_inst_o;
    logic [PC_W-1:0]   id_pc_o;

    modport master (output id_valid_o, output id_inst_o, output id_pc_o, input  id_ready_i);
    modport slave  (input  id_valid_o, input  id_inst_o, input  id_pc_o, output id_ready_i);
endinterface

// File: rtl/fetch_next_pc.sv
// Sequential next-PC: local j-target decode, otherwise increment with natural wrap.
module fetch_next_pc
    import mips_pkg::*;
#(
    parameter int PC_W = 5
) (
    input  logic [PC_W-1:0] pc,
    input  logic [5:0]      opcode,
    input  logic [PC_W-1:0] jtarget,
    output logic [PC_W-1:0] next_pc
);

    always_comb begin
        next_pc = pc + PC_W'(1);
        if (opcode == OP_J) next_pc = jtarget;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, addresses the external ROM and registers
// the returned word into the IF/ID entry. Branch redirects come from execute.
module inst_fetch #(
    parameter int              PC_W     = 5,
    parameter int              INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    output logic [PC_W-1:0]   pc_o,
    input  logic [INST_W-1:0] inst_i,
    input  logic              redirect_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    inst_fetch_if.master      id,
    output logic [15:0]       fetch_cnt_o
);
    import mips_pkg::*;

    fetch_state_e      state;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   next_pc;
    logic              id_valid_q;
    logic [INST_W-1:0] id_inst_q;
    logic [PC_W-1:0]   id_pc_q;
    logic              fire;

    fetch_next_pc #(.PC_W(PC_W)) u_next_pc (
        .pc      (pc_q),
        .opcode  (inst_i[INST_W-1 -: 6]),
        .jtarget (inst_i[PC_W-1:0]),
        .next_pc (next_pc)
    );

    // id_ready_i only reaches flop enables; pc_o stays a pure register output.
    assign fire = (state == RUN) && !redirect_i && (!id_valid_q || id.id_ready_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc_q        <= RESET_PC;
            id_valid_q  <= 1'b0;
            id_inst_q   <= '0;
            id_pc_q     <= '0;
            fetch_cnt_o <= '0;
        end else begin
            case (state)
                IDLE:    if (enable_i)  state <= RUN;
                RUN:     if (!enable_i) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (redirect_i) begin
                pc_q       <= redirect_pc_i;
                id_valid_q <= 1'b0;
            end else if (fire) begin
                id_inst_q  <= inst_i;
                id_pc_q    <= pc_q;
                id_valid_q <= 1'b1;
                pc_q       <= next_pc;
                if (fetch_cnt_o != 16'hFFFF) fetch_cnt_o <= fetch_cnt_o + 16'd1;
            end else if (id_valid_q && id.id_ready_i) begin
                id_valid_q <= 1'b0;
            end
        end
    end

    assign pc_o          = pc_q;
    assign id.id_valid_o = id_valid_q;
    assign id.id_inst_o  = id_inst_q;
    assign id.id_pc_o    = id_pc_q;

endmodule
